ovf_detector_dr_seq: RTL and testbench
======================================

// Module: ovf_detector_dr_seq
// PURPOSE
//   Parametrised, clocked successor of the ULA dual-rail overflow detector. Takes dual-rail
//   (NCL-style) operands A, B, the add/sub result and a dual-rail op select, and emits a
//   dual-rail overflow flag. Runs a synchronous four-phase DATA/NULL handshake (ko), flags
//   illegal rail codes and counts overflow events. Sits after the ULA adder/subtractor.
// PARAMETERS
//   W      8  operand width in bits (each bit is one rail pair, so buses are 2*W wide)
//   CNT_W  8  width of the saturating overflow event counter
// PORTS
//   clk        in   1      clock, rising edge
//   rst        in   1      synchronous reset, active-high
//   a_dr       in   2*W    operand A; bit i = {a_dr[2i+1]=true rail, a_dr[2i]=false rail}
//   b_dr       in   2*W    operand B, same encoding
//   res_dr     in   2*W    add/sub result from the adder, same encoding
//   sel_dr     in   4      op select, 2 dual-rail bits {s1.t,s1.f,s0.t,s0.f}; 00=ADD 01=SUB 1x=non-arith
//   clr        in   1      clears err, ovf_cnt and ovf_sticky (sync, 1 cycle)
//   ovf_dr     out  2      overflow flag {true,false}; 00=NULL, 10=overflow, 01=no overflow
//   ko         out  1      1 = requesting DATA, 0 = requesting NULL
//   err        out  1      sticky: illegal rail code (11) seen on any input pair
//   ovf_cnt    out  CNT_W  count of DATA wavefronts with overflow, saturating at all-ones
//   ovf_sticky out  1      sticky overflow (see CONFIGURATION)
// BEHAVIOUR
//   Reset (rst=1 at edge): state=WAIT_DATA, ovf_dr=00, ko=1, err=0, ovf_cnt=0, ovf_sticky=0.
//   Pair classes: NULL=00, DATA=01/10, ILLEGAL=11. Input set = a_dr,b_dr,res_dr,sel_dr.
//   COMPLETE = every pair DATA; EMPTY = every pair NULL; otherwise PARTIAL.
//   FSM (2 states, evaluated on each rising edge):
//     WAIT_DATA: COMPLETE -> HOLD_DATA; ovf_dr <= result; ko <= 0; count update.
//                PARTIAL/EMPTY -> stay; ovf_dr stays 00.
//     HOLD_DATA: EMPTY -> WAIT_DATA; ovf_dr <= 00; ko <= 1.
//                COMPLETE/PARTIAL -> stay; ovf_dr held (input changes during DATA ignored).
//   Latency: ovf_dr and ko change 1 cycle after the sampled input set reaches COMPLETE/EMPTY.
//   Overflow (on decoded true rails, MSB = bit W-1):
//     ADD: ovf = (a[W-1]==b[W-1]) & (res[W-1]!=a[W-1])
//     SUB: ovf = (a[W-1]!=b[W-1]) & (res[W-1]!=a[W-1])
//     non-arith: ovf = 0 (ovf_dr=01).
//   ILLEGAL on any pair: err <= 1 that edge; state, ovf_dr, ko unchanged; treated as PARTIAL.
//   Counter: +1 on WAIT_DATA->HOLD_DATA with ovf=1; holds at 2^CNT_W-1 (no wrap).
//   clr and count increment same edge: clr wins (cnt=0). clr does not touch FSM/ovf_dr/ko.
//   rst mid-HOLD_DATA: return to reset values next edge; upstream must re-present NULL/DATA.
//   ovf_dr never 11; never transitions DATA->DATA without an intervening 00.
// CONFIGURATION
//   OVF_DETECTOR_STICKY_EN defined: ovf_sticky <= 1 on every counted overflow; cleared only
//     by rst or clr (clr priority over same-edge set).
//   Not defined: ovf_sticky tied 0; port kept for interface stability; all else identical.
// TESTING
//   W=8, ADD a=0x7F b=0x01 res=0x80 all DATA -> next cycle ovf_dr=10, ko=0, ovf_cnt=1.
//   Then drive all NULL -> next cycle ovf_dr=00, ko=1; ADD a=0x10 b=0x20 res=0x30 -> ovf_dr=01.
//   SUB a=0x80 b=0x01 res=0x7F -> ovf_dr=10; sel=1x with same operands -> ovf_dr=01.
//   Drive only a_dr DATA (others NULL) for 5 cycles -> ovf_dr=00, ko=1 throughout; set
//     a_dr bit0 pair=11 -> err=1 next cycle, state unchanged; clr -> err=0.
//   CNT_W=2: 4 overflow wavefronts -> ovf_cnt=3 (saturated); clr on same edge as 5th -> 0.
//   rst asserted while HOLD_DATA -> next cycle ovf_dr=00, ko=1, ovf_cnt=0; with
//     OVF_DETECTOR_STICKY_EN ovf_sticky 1->0; without it ovf_sticky always 0.

Source files
------------

// File: rtl/ovf_detector_dr_seq_if.sv
// Bundle of the dual-rail operand, select, control and status signals
// for ovf_detector_dr_seq. The master modport drives operands and the
// slave modport is the detector itself.
interface ovf_detector_dr_seq_if #(
  parameter int unsigned W     = 8,
  parameter int unsigned CNT_W = 8
);
  logic [2*W-1:0]   a_dr;
  logic [2*W-1:0]   b_dr;
  logic [2*W-1:0]   res_dr;
  logic [3:0]       sel_dr;
  logic             clr;
  logic [1:0]       ovf_dr;
  logic             ko;
  logic             err;
  logic [CNT_W-1:0] ovf_cnt;
  logic             ovf_sticky;

  modport master (
    output a_dr, b_dr, res_dr, sel_dr, clr,
    input  ovf_dr, ko, err, ovf_cnt, ovf_sticky
  );

  modport slave (
    input  a_dr, b_dr, res_dr, sel_dr, clr,
    output ovf_dr, ko, err, ovf_cnt, ovf_sticky
  );
endinterface

// File: rtl/ovf_detector_dr_seq.sv
// Clocked dual-rail overflow detector with a four-phase DATA/NULL
// handshake (ko), sticky illegal-code flag and saturating overflow
// event counter.
// Optional feature: define OVF_DETECTOR_STICKY_EN to enable the sticky
// overflow flag; otherwise ovf_sticky is tied low.
module ovf_detector_dr_seq #(
  parameter int unsigned W     = 8,
  parameter int unsigned CNT_W = 8
) (
  input logic                  clk,
  input logic                  rst,
  ovf_detector_dr_seq_if.slave bus
);

  localparam logic [0:0] WAIT_DATA = 1'b0;
  localparam logic [0:0] HOLD_DATA = 1'b1;

  // Number of rail pairs in the full input set: A, B, result and 2 select bits.
  localparam int unsigned NP = 3 * W + 2;

  logic [2*NP-1:0]  pairs;
  logic             any_ill;
  logic             all_data;
  logic             all_null;
  logic             ovf;
  logic             count_evt;

  logic [0:0]       state_q, state_d;
  logic [1:0]       ovf_dr_q, ovf_dr_d;
  logic             ko_q, ko_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] ovf_cnt_q, ovf_cnt_d;

  assign pairs = {bus.sel_dr, bus.res_dr, bus.b_dr, bus.a_dr};

  // Classify the whole input set as complete DATA, all NULL, or carrying an illegal code.
  always_comb begin
    any_ill  = 1'b0;
    all_data = 1'b1;
    all_null = 1'b1;
    for (int unsigned i = 0; i < NP; i++) begin
      case (pairs[2*i +: 2])
        2'b00:   all_data = 1'b0;
        2'b11: begin
          any_ill  = 1'b1;
          all_data = 1'b0;
          all_null = 1'b0;
        end
        default: all_null = 1'b0;
      endcase
    end
  end

  // Signed overflow from the MSB true rails; only meaningful when the set is complete.
  always_comb begin
    ovf = 1'b0;
    if (!bus.sel_dr[3]) begin
      if (bus.sel_dr[1])
        ovf = (bus.a_dr[2*W-1] != bus.b_dr[2*W-1]) && (bus.res_dr[2*W-1] != bus.a_dr[2*W-1]);
      else
        ovf = (bus.a_dr[2*W-1] == bus.b_dr[2*W-1]) && (bus.res_dr[2*W-1] != bus.a_dr[2*W-1]);
    end
  end

  // Handshake FSM, error flag and counter next-state; clr overrides same-edge updates.
  always_comb begin
    state_d   = state_q;
    ovf_dr_d  = ovf_dr_q;
    ko_d      = ko_q;
    err_d     = err_q;
    ovf_cnt_d = ovf_cnt_q;
    count_evt = 1'b0;
    if (any_ill) begin
      err_d = 1'b1;
    end else begin
      case (state_q)
        WAIT_DATA: begin
          if (all_data) begin
            state_d   = HOLD_DATA;
            ovf_dr_d  = ovf ? 2'b10 : 2'b01;
            ko_d      = 1'b0;
            count_evt = ovf;
          end
        end
        HOLD_DATA: begin
          if (all_null) begin
            state_d  = WAIT_DATA;
            ovf_dr_d = 2'b00;
            ko_d     = 1'b1;
          end
        end
        default: state_d = WAIT_DATA;
      endcase
    end
    if (count_evt && (ovf_cnt_q != '1))
      ovf_cnt_d = ovf_cnt_q + 1'b1;
    if (bus.clr) begin
      err_d     = 1'b0;
      ovf_cnt_d = '0;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= WAIT_DATA;
      ovf_dr_q  <= 2'b00;
      ko_q      <= 1'b1;
      err_q     <= 1'b0;
      ovf_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      ovf_dr_q  <= ovf_dr_d;
      ko_q      <= ko_d;
      err_q     <= err_d;
      ovf_cnt_q <= ovf_cnt_d;
    end
  end

`ifdef OVF_DETECTOR_STICKY_EN
  logic ovf_sticky_q, ovf_sticky_d;

  // Sticky overflow: set on each counted overflow, cleared by clr with priority.
  always_comb begin
    ovf_sticky_d = ovf_sticky_q;
    if (count_evt)
      ovf_sticky_d = 1'b1;
    if (bus.clr)
      ovf_sticky_d = 1'b0;
  end

  // Sticky flag register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst)
      ovf_sticky_q <= 1'b0;
    else
      ovf_sticky_q <= ovf_sticky_d;
  end

  assign bus.ovf_sticky = ovf_sticky_q;
`else
  assign bus.ovf_sticky = 1'b0;
`endif

  assign bus.ovf_dr  = ovf_dr_q;
  assign bus.ko      = ko_q;
  assign bus.err     = err_q;
  assign bus.ovf_cnt = ovf_cnt_q;

endmodule

// File: tb/tb_ovf_detector_dr_seq.sv
// Self-checking bench for ovf_detector_dr_seq: directed table plus
// randomized stimulus against a behavioural model. Two instances share
// the stimulus: CNT_W=8 and CNT_W=2 (for counter saturation).
module tb_ovf_detector_dr_seq;

`ifdef OVF_DETECTOR_STICKY_EN
  localparam bit STK_EN = 1'b1;
`else
  localparam bit STK_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ovf_detector_dr_seq_if #(.W(8), .CNT_W(8)) if8 ();
  ovf_detector_dr_seq_if #(.W(8), .CNT_W(2)) if2 ();

  logic [15:0] a_dr_s, b_dr_s, res_dr_s;
  logic [3:0]  sel_dr_s;
  logic        clr_s;

  assign if8.a_dr = a_dr_s;   assign if2.a_dr = a_dr_s;
  assign if8.b_dr = b_dr_s;   assign if2.b_dr = b_dr_s;
  assign if8.res_dr = res_dr_s; assign if2.res_dr = res_dr_s;
  assign if8.sel_dr = sel_dr_s; assign if2.sel_dr = sel_dr_s;
  assign if8.clr = clr_s;     assign if2.clr = clr_s;

  ovf_detector_dr_seq #(.W(8), .CNT_W(8)) dut8 (.clk(clk), .rst(rst), .bus(if8.slave));
  ovf_detector_dr_seq #(.W(8), .CNT_W(2)) dut2 (.clk(clk), .rst(rst), .bus(if2.slave));

  // Stimulus description: values plus per-bit valid (DATA) and illegal masks.
  logic [7:0] a_v, b_v, r_v, a_m, b_m, r_m, ill_a;
  logic [1:0] s_v, s_m;

  int n_chk = 0;
  int n_fail = 0;

  // Behavioural model state
  bit         m_busy;
  logic [1:0] m_ovf;
  bit         m_err, m_stk;
  int         m_c8, m_c2;

  typedef struct {
    bit         rst;
    bit         clr;
    int         kind;   // 0 all NULL, 1 all DATA, 2 only A DATA
    logic [7:0] a, b, r;
    logic [1:0] sel;
    logic [7:0] ill;
    logic [1:0] e_ovf;
    bit         e_ko, e_err;
    int         e_c8, e_c2;
    bit         e_stk;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [15:0] enc8(input logic [7:0] v, input logic [7:0] vld, input logic [7:0] ill);
    logic [15:0] r;
    for (int i = 0; i < 8; i++)
      r[2*i +: 2] = ill[i] ? 2'b11 : (vld[i] ? (v[i] ? 2'b10 : 2'b01) : 2'b00);
    return r;
  endfunction

  function automatic logic [3:0] enc2(input logic [1:0] v, input logic [1:0] vld);
    logic [3:0] r;
    for (int i = 0; i < 2; i++)
      r[2*i +: 2] = vld[i] ? (v[i] ? 2'b10 : 2'b01) : 2'b00;
    return r;
  endfunction

  function automatic vec_t mk(bit rs, bit cl, int kind, logic [7:0] a, logic [7:0] b, logic [7:0] r,
                              logic [1:0] sel, logic [7:0] ill, logic [1:0] eo, bit eko, bit eer,
                              int c8, int c2, bit estk);
    vec_t t;
    t.rst = rs; t.clr = cl; t.kind = kind; t.a = a; t.b = b; t.r = r; t.sel = sel; t.ill = ill;
    t.e_ovf = eo; t.e_ko = eko; t.e_err = eer; t.e_c8 = c8; t.e_c2 = c2; t.e_stk = estk;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // Signed-overflow rule applied to the decoded operands as two's-complement numbers.
  function automatic bit model_ovf();
    int sa, sb, sr;
    sa = int'($signed(a_v));
    sb = int'($signed(b_v));
    sr = int'($signed(r_v));
    if (s_v[1]) return 1'b0;
    if (s_v[0]) return ((sa < 0) != (sb < 0)) && ((sr < 0) != (sa < 0));
    return ((sa < 0) == (sb < 0)) && ((sr < 0) != (sa < 0));
  endfunction

  task automatic model_step();
    bit anyill, comp, empt, ov;
    anyill = (ill_a != 8'h00);
    comp = !anyill && a_m == 8'hFF && b_m == 8'hFF && r_m == 8'hFF && s_m == 2'b11;
    empt = !anyill && a_m == 8'h00 && b_m == 8'h00 && r_m == 8'h00 && s_m == 2'b00;
    if (rst) begin
      m_busy = 0; m_ovf = 2'b00; m_err = 0; m_c8 = 0; m_c2 = 0; m_stk = 0;
    end else begin
      if (anyill) begin
        m_err = 1;
      end else if (!m_busy && comp) begin
        m_busy = 1;
        ov = model_ovf();
        m_ovf = ov ? 2'b10 : 2'b01;
        if (ov) begin
          m_c8 = (m_c8 < 255) ? m_c8 + 1 : 255;
          m_c2 = (m_c2 < 3) ? m_c2 + 1 : 3;
          m_stk = 1;
        end
      end else if (m_busy && empt) begin
        m_busy = 0;
        m_ovf = 2'b00;
      end
      if (clr_s) begin
        m_err = 0; m_c8 = 0; m_c2 = 0; m_stk = 0;
      end
    end
  endtask

  task automatic step();
    a_dr_s   = enc8(a_v, a_m, ill_a);
    b_dr_s   = enc8(b_v, b_m, 8'h00);
    res_dr_s = enc8(r_v, r_m, 8'h00);
    sel_dr_s = enc2(s_v, s_m);
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic set_kind(input int kind);
    case (kind)
      1:       begin a_m = 8'hFF; b_m = 8'hFF; r_m = 8'hFF; s_m = 2'b11; end
      2:       begin a_m = 8'hFF; b_m = 8'h00; r_m = 8'h00; s_m = 2'b00; end
      default: begin a_m = 8'h00; b_m = 8'h00; r_m = 8'h00; s_m = 2'b00; end
    endcase
  endtask

  initial begin
    m_busy = 0; m_ovf = 2'b00; m_err = 0; m_c8 = 0; m_c2 = 0; m_stk = 0;
    rst = 1'b1; clr_s = 1'b0;
    a_v = '0; b_v = '0; r_v = '0; s_v = '0; ill_a = '0;
    set_kind(0);

    //            rst clr kind a      b      r      sel   ill    eovf  ko err c8 c2 stk
    tbl.push_back(mk(1, 0, 0, 8'h00, 8'h00, 8'h00, 2'd0, 8'h00, 2'b00, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 8'h7F, 8'h01, 8'h80, 2'd0, 8'h00, 2'b10, 0, 0, 1, 1, 1));
    tbl.push_back(mk(0, 0, 1, 8'h10, 8'h20, 8'h30, 2'd0, 8'h00, 2'b10, 0, 0, 1, 1, 1));
    tbl.push_back(mk(0, 0, 2, 8'h10, 8'h20, 8'h30, 2'd0, 8'h00, 2'b10, 0, 0, 1, 1, 1));
    tbl.push_back(mk(0, 0, 0, 8'h00, 8'h00, 8'h00, 2'd0, 8'h00, 2'b00, 1, 0, 1, 1, 1));
    tbl.push_back(mk(0, 0, 1, 8'h10, 8'h20, 8'h30, 2'd0, 8'h00, 2'b01, 0, 0, 1, 1, 1));
    tbl.push_back(mk(0, 0, 0, 8'h00, 8'h00, 8'h00, 2'd0, 8'h00, 2'b00, 1, 0, 1, 1, 1));
    tbl.push_back(mk(0, 0, 1, 8'h80, 8'h01, 8'h7F, 2'd1, 8'h00, 2'b10, 0, 0, 2, 2, 1));
    tbl.push_back(mk(0, 0, 0, 8'h00, 8'h00, 8'h00, 2'd0, 8'h00, 2'b00, 1, 0, 2, 2, 1));
    tbl.push_back(mk(0, 0, 1, 8'h80, 8'h01, 8'h7F, 2'd2, 8'h00, 2'b01, 0, 0, 2, 2, 1));
    tbl.push_back(mk(0, 0, 0, 8'h00, 8'h00, 8'h00, 2'd0, 8'h00, 2'b00, 1, 0, 2, 2, 1));
    for (int i = 0; i < 5; i++)
      tbl.push_back(mk(0, 0, 2, 8'h55, 8'h00, 8'h00, 2'd0, 8'h00, 2'b00, 1, 0, 2, 2, 1));
    tbl.push_back(mk(0, 0, 2, 8'h55, 8'h00, 8'h00, 2'd0, 8'h01, 2'b00, 1, 1, 2, 2, 1));
    tbl.push_back(mk(0, 1, 0, 8'h00, 8'h00, 8'h00, 2'd0, 8'h00, 2'b00, 1, 0, 0, 0, 0));
    // four overflow wavefronts: 2-bit counter saturates at 3
    for (int i = 1; i <= 4; i++) begin
      tbl.push_back(mk(0, 0, 1, 8'h7F, 8'h01, 8'h80, 2'd0, 8'h00, 2'b10, 0, 0, i, (i > 3) ? 3 : i, 1));
      tbl.push_back(mk(0, 0, 0, 8'h00, 8'h00, 8'h00, 2'd0, 8'h00, 2'b00, 1, 0, i, (i > 3) ? 3 : i, 1));
    end
    // fifth overflow with clr on the same edge
    tbl.push_back(mk(0, 1, 1, 8'h7F, 8'h01, 8'h80, 2'd0, 8'h00, 2'b10, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 8'h00, 8'h00, 8'h00, 2'd0, 8'h00, 2'b00, 1, 0, 0, 0, 0));
    // reset while holding DATA
    tbl.push_back(mk(0, 0, 1, 8'h7F, 8'h01, 8'h80, 2'd0, 8'h00, 2'b10, 0, 0, 1, 1, 1));
    tbl.push_back(mk(1, 0, 1, 8'h7F, 8'h01, 8'h80, 2'd0, 8'h00, 2'b00, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 8'h00, 8'h00, 8'h00, 2'd0, 8'h00, 2'b00, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 8'h7F, 8'h01, 8'h80, 2'd0, 8'h00, 2'b10, 0, 0, 1, 1, 1));
    tbl.push_back(mk(0, 0, 0, 8'h00, 8'h00, 8'h00, 2'd0, 8'h00, 2'b00, 1, 0, 1, 1, 1));

    foreach (tbl[k]) begin
      rst = tbl[k].rst; clr_s = tbl[k].clr;
      a_v = tbl[k].a; b_v = tbl[k].b; r_v = tbl[k].r; s_v = tbl[k].sel;
      ill_a = tbl[k].ill;
      set_kind(tbl[k].kind);
      step();
      chk($sformatf("t%0d_ovf_dr", k), 32'(if8.ovf_dr), 32'(tbl[k].e_ovf));
      chk($sformatf("t%0d_ko", k), 32'(if8.ko), 32'(tbl[k].e_ko));
      chk($sformatf("t%0d_err", k), 32'(if8.err), 32'(tbl[k].e_err));
      chk($sformatf("t%0d_ovf_cnt", k), 32'(if8.ovf_cnt), 32'(tbl[k].e_c8));
      chk($sformatf("t%0d_ovf_sticky", k), 32'(if8.ovf_sticky), 32'(STK_EN & tbl[k].e_stk));
      chk($sformatf("t%0d_cnt2_ovf_dr", k), 32'(if2.ovf_dr), 32'(tbl[k].e_ovf));
      chk($sformatf("t%0d_cnt2_ovf_cnt", k), 32'(if2.ovf_cnt), 32'(tbl[k].e_c2));
    end

    // Randomized phase against the behavioural model
    for (int n = 0; n < 2000; n++) begin
      int sel;
      sel = $urandom_range(0, 99);
      rst   = ($urandom_range(0, 199) == 0);
      clr_s = ($urandom_range(0, 39) == 0);
      a_v = 8'($urandom); b_v = 8'($urandom); r_v = 8'($urandom); s_v = 2'($urandom);
      ill_a = ($urandom_range(0, 29) == 0) ? (8'h01 << $urandom_range(0, 7)) : 8'h00;
      if (sel < 40) set_kind(1);
      else if (sel < 75) set_kind(0);
      else begin
        a_m = ($urandom_range(0, 1) == 1) ? 8'hFF : 8'($urandom);
        b_m = ($urandom_range(0, 1) == 1) ? 8'hFF : 8'($urandom);
        r_m = ($urandom_range(0, 1) == 1) ? 8'h00 : 8'($urandom);
        s_m = 2'($urandom);
      end
      step();
      chk("rnd_ovf_dr", 32'(if8.ovf_dr), 32'(m_ovf));
      chk("rnd_ko", 32'(if8.ko), 32'(!m_busy));
      chk("rnd_err", 32'(if8.err), 32'(m_err));
      chk("rnd_ovf_cnt", 32'(if8.ovf_cnt), 32'(m_c8));
      chk("rnd_ovf_sticky", 32'(if8.ovf_sticky), 32'(STK_EN & m_stk));
      chk("rnd_cnt2_ovf_dr", 32'(if2.ovf_dr), 32'(m_ovf));
      chk("rnd_cnt2_ko", 32'(if2.ko), 32'(!m_busy));
      chk("rnd_cnt2_err", 32'(if2.err), 32'(m_err));
      chk("rnd_cnt2_ovf_cnt", 32'(if2.ovf_cnt), 32'(m_c2));
      chk("rnd_cnt2_ovf_sticky", 32'(if2.ovf_sticky), 32'(STK_EN & m_stk));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
